dmem_responder: RTL
===================

# dmem_responder

Data-memory responder: the slave end of the core's load/store port (`wr`, `rd`, `addr`, `wr_data`, `rd_data`). It answers core-initiated accesses with byte/half/word granularity and a configurable multi-cycle read latency, raising `stall` so the pipeline holds while a load is outstanding. It instantiates under the `riscv` top, next to the datapath, and replaces the zero-latency data memory for latency-tolerance testing.

## Interface
- `DATA_W`, default 32: data width. Only 32 is supported.
- `ADDR_W`, default 9: byte-address width. The array holds 2^(ADDR_W-2) words.
- `RD_LAT`, default 2: read latency in cycles. Legal range is 1..8.
- `clk`  input  1  clock. All state changes on the rising edge.
- `reset`  input  1  reset, synchronous and active-low.
- `wr`  input  1  store request.
- `rd`  input  1  load request.
- `addr`  input  ADDR_W  byte address. `addr[ADDR_W-1:2]` selects the word; `addr[1:0]` selects the lane.
- `funct3`  input  3  access size and sign: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- `wr_data`  input  DATA_W  store data, right-aligned.
- `rd_data`  output  DATA_W  load result, extended. Registered.
- `rd_valid`  output  1  `rd_data` is valid this cycle. Registered.
- `stall`  output  1  the core must hold its memory stage.
- `err`  output  1  misaligned-access flag. Registered. Tied 0 when the macro is absent.

## Operation
- FSM states: IDLE, WAIT, DONE. A request is accepted only in IDLE.
- IDLE with `wr`=1: the store commits at the edge. No stall. Lanes written:
  - SB: lane `addr[1:0]`, taking `wr_data[7:0]`.
  - SH: lanes `{addr[1],0}` and `{addr[1],1}`, taking `wr_data[15:0]`.
  - SW: all four lanes.
  - Other `funct3` values write nothing.
- IDLE with `rd`=1 and `wr`=0: `addr` and `funct3` are captured and `cnt` is set to RD_LAT-1. Next state is DONE if `cnt`=0, otherwise WAIT.
- IDLE with `wr` and `rd` both 1: the store wins and the read is dropped.
- WAIT: `cnt` decrements each cycle. The state moves to DONE on the edge where `cnt`=1.
- On the edge entering DONE, `rd_data` is loaded from the captured word:
  - LB/LBU: lane `addr[1:0]`, sign- or zero-extended.
  - LH/LHU: halfword `addr[1]`, sign- or zero-extended.
  - LW: the whole word.
  - Other `funct3` values give 0.
- DONE: `rd_valid`=1 and `stall`=0, so the core advances at this edge. DONE always returns to IDLE. `rd`/`wr` are ignored in DONE because they still belong to the finishing load.
- `stall` = `(IDLE & rd & !wr) | WAIT`. It is forced to 0 while `reset`=0.
- The memory array has no reset. Contents survive reset.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `err`=0, state=IDLE, `cnt`=0, `stall`=0.
- Store latency is 0 stall cycles. The data is readable by any load accepted after the store's edge.
- Load issued in cycle 0:
  - `stall` is high in cycles 0..RD_LAT-1.
  - `rd_valid`/`rd_data` are presented in cycle RD_LAT, for exactly one cycle.
- `rd_data` holds its last value after DONE. `rd_valid` returns to 0.
- Reset mid-read (WAIT or DONE): next state is IDLE, `rd_valid`=0, and the pending load is discarded.
- Address wrap: none. `addr` is exactly ADDR_W bits, so every address maps into the array.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A misaligned access sets `err`=1 for one cycle on the edge after acceptance. Misaligned means LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - A misaligned store writes nothing.
  - A misaligned load completes normal timing but returns `rd_data`=0.
- `DMEM_MISALIGN_TRAP_EN` not defined:
  - `err` is tied 0.
  - Misaligned halfword accesses use `addr[1]` only (`addr[0]` ignored). Misaligned word accesses ignore `addr[1:0]`.

## Structure
- Package `dmem_pkg` holds:
  - the `funct3` constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum `dmem_state_t`;
  - the lane-mask function (size and `addr[1:0]` to a 4-bit byte enable).
- Sub-module `dmem_array`: 2^(ADDR_W-2) × 32 storage with 4-bit byte-enable write and one read port. The read is combinational, and the FSM registers it into `rd_data`.
- The FSM, counter and extension logic stay in `dmem_responder`.

## Test plan
- Byte store and load at RD_LAT=2: SW 0xDEADBEEF @0x010, then SB 0x7F @0x011, then LB @0x011 → `rd_data`=0x0000007F. Then LBU @0x013 → 0x000000DE. Each load shows `stall` for 2 cycles and `rd_valid` in cycle 2.
- Sign extension: SH 0x8001 @0x022, then LH @0x022 → 0xFFFF8001, then LHU @0x022 → 0x00008001.
- Latency sweep: RD_LAT = 1, 4 and 8. Each load shows `stall` high for exactly RD_LAT cycles and a single `rd_valid` pulse. A store issued in the cycle after DONE commits with no stall.
- Simultaneous requests: `wr`=`rd`=1 with SW 0x12345678 @0x040 → no stall, no `rd_valid`, and a later LW @0x040 → 0x12345678.
- Reset mid-read: LW issued at RD_LAT=4, `reset`=0 in cycle 2 → `stall`=0 and `rd_valid` never pulses. Memory contents are intact on a later LW.
- With `DMEM_MISALIGN_TRAP_EN` defined: SW @0x042 → `err` pulses for one cycle and a later LW @0x040 is unchanged. LH @0x041 → `err`=1 and `rd_data`=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes,
// FSM state encoding and byte-lane helpers.
// Used by dmem_responder and dmem_array.
package dmem_pkg;

    // Access size/sign codes, shared by loads and stores (stores use B/H/W only)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Byte enable for an access of the given size (funct3[1:0]) at the given lane.
    // Halfwords pick their half from lane[1]; words cover all lanes, so
    // low address bits that do not fit the size are simply ignored.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Misalignment test; HU only exists as a load, so it is not a store code.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane,
                                        input logic is_load);
        logic half;
        logic word;
        half = (f3 == F3_H) || (is_load && (f3 == F3_HU));
        word = (f3 == F3_W);
        return (half && lane[0]) || (word && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage, 2^(ADDR_W-2) x 32, byte-enable write, combinational read.
// Ports: clk; we/be/waddr/wdata write port; raddr/rdata read port.
// No reset: contents persist across core resets.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-3:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-3:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**(ADDR_W-2)];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: zero-stall stores, RD_LAT-cycle loads.
// Ports: clk/reset (sync, active-low); wr/rd/addr/funct3/wr_data request; rd_data/rd_valid/stall/err.
// Optional DMEM_MISALIGN_TRAP_EN: flag misaligned accesses on err, drop such stores, zero such loads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    output logic              err
);

    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    dmem_state_t       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;

    logic              idle;
    logic              st_bad;
    logic              ld_bad;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       word;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_f3;

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'd0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'd0, h};
            F3_W:    return w;
            default: return 32'd0;
        endcase
    endfunction

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (we),
        .be    (be),
        .waddr (addr[ADDR_W-1:2]),
        .wdata (wdata),
        .raddr (ld_addr[ADDR_W-1:2]),
        .rdata (word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            f3_q       <= 3'd0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        case (state_q)
            IDLE: begin
                // A simultaneous store wins; the read is dropped.
                if (rd && !wr) begin
                    addr_d  = addr;
                    f3_d    = funct3;
                    cnt_d   = LAT_M1;
                    state_d = (LAT_M1 == 3'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath
    always_comb begin
        idle  = (state_q == IDLE);
        stall = reset && ((idle && rd && !wr) || (state_q == WAIT));

        // For RD_LAT=1 the load goes straight from IDLE to DONE before the
        // request is captured, so the live address feeds the array then.
        ld_addr = idle ? addr : addr_q;
        ld_f3   = idle ? funct3 : f3_q;

        case (funct3[1:0])
            2'b00:   wdata = {4{wr_data[7:0]}};
            2'b01:   wdata = {2{wr_data[15:0]}};
            default: wdata = wr_data;
        endcase
        be = funct3[2] ? 4'b0000 : lane_mask(funct3[1:0], addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
        st_bad = misaligned(funct3, addr[1:0], 1'b0);
        ld_bad = misaligned(ld_f3, ld_addr[1:0], 1'b1);
`else
        st_bad = 1'b0;
        ld_bad = 1'b0;
`endif

        we         = reset && idle && wr && !st_bad && (be != 4'b0000);
        rd_valid_d = (state_d == DONE);
        rd_data_d  = rd_data_q;
        if (rd_valid_d) begin
            rd_data_d = ld_bad ? '0 : load_extend(word, ld_f3, ld_addr[1:0]);
        end
        err_d = idle && (wr ? st_bad : (rd && ld_bad));
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule
